// File: rtl/pwm_param_ctrl.sv
// pwm_param_ctrl
//   Turns debounced key events into PWM duty and dead-time settings.
//   Edits land in shadow registers. They are copied to the committed outputs
//   only at a PWM period boundary, so the PWM core never sees a change in the
//   middle of a period.
//
// Ports
//   clock        in   system clock; all logic on rising edge
//   reset        in   asynchronous, active-low reset
//   keyVal[3:0]  in   active-low one-cycle key pulses:
//                     [0] duty up, [1] duty down, [2] dead up, [3] dead down
//   period_end   in   one-cycle pulse from the PWM counter at period wrap
//   duty_out     out  committed duty
//   dead_out     out  committed dead time
//   upd_pending  out  shadow edit waiting for the next period_end
//   sat          out  one-cycle pulse: an accepted key was clamped at a limit
//
// Optional feature (macro DEAD_CLAMP_EN)
//   When defined, the dead shadow is also clamped after every update so that
//   2*dead <= min(duty, DUTY_MAX-duty). The clamp uses the new duty shadow.
//
// Commit FSM
//   state   | meaning
//   IDLE    | shadow matches committed outputs
//   PENDING | shadow edited, copy to outputs on next period_end

module pwm_param_ctrl #(
  parameter int DUTY_W    = 8,
  parameter int DEAD_W    = 6,
  parameter int DUTY_MAX  = 100,
  parameter int DUTY_STEP = 5,
  parameter int DUTY_INIT = 50,
  parameter int DEAD_MAX  = 40,
  parameter int DEAD_STEP = 1,
  parameter int DEAD_INIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        keyVal,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic [DEAD_W-1:0] dead_out,
  output logic              upd_pending,
  output logic              sat
);

  localparam logic [DUTY_W:0] DUTY_MAX_X  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0] DUTY_STEP_X = (DUTY_W+1)'(DUTY_STEP);
  localparam logic [DEAD_W:0] DEAD_MAX_X  = (DEAD_W+1)'(DEAD_MAX);
  localparam logic [DEAD_W:0] DEAD_STEP_X = (DEAD_W+1)'(DEAD_STEP);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [DUTY_W-1:0] duty_sh, duty_nx;
  logic [DEAD_W-1:0] dead_sh, dead_nx;
  logic [DUTY_W:0]   duty_up_x, duty_dn_x;
  logic [DEAD_W:0]   dead_up_x, dead_dn_x;
  logic              duty_up, duty_dn, dead_up, dead_dn;
  logic              clamp;
  logic              changed;
  logic              commit;

`ifdef DEAD_CLAMP_EN
  localparam int CW = (DUTY_W > DEAD_W) ? DUTY_W : DEAD_W;
  localparam logic [DUTY_W-1:0] DUTY_MAX_D = DUTY_W'(DUTY_MAX);
  logic [DUTY_W-1:0] duty_rem, duty_min, dead_lim;
`endif

  assign duty_up = ~keyVal[0];
  assign duty_dn = ~keyVal[1];
  assign dead_up = ~keyVal[2];
  assign dead_dn = ~keyVal[3];

  // Shadow next-value and saturation detection. The sums carry one extra bit,
  // so overflow past the limit and underflow below zero are both visible
  // before clamping.
  always_comb begin
    duty_up_x = {1'b0, duty_sh} + DUTY_STEP_X;
    duty_dn_x = {1'b0, duty_sh} - DUTY_STEP_X;
    dead_up_x = {1'b0, dead_sh} + DEAD_STEP_X;
    dead_dn_x = {1'b0, dead_sh} - DEAD_STEP_X;
    duty_nx   = duty_sh;
    dead_nx   = dead_sh;
    clamp     = 1'b0;

    if (duty_up && !duty_dn) begin
      if (duty_up_x > DUTY_MAX_X) begin
        duty_nx = DUTY_MAX_X[DUTY_W-1:0];
        clamp   = 1'b1;
      end else begin
        duty_nx = duty_up_x[DUTY_W-1:0];
      end
    end else if (duty_dn && !duty_up) begin
      if (duty_dn_x[DUTY_W]) begin
        duty_nx = '0;
        clamp   = 1'b1;
      end else begin
        duty_nx = duty_dn_x[DUTY_W-1:0];
      end
    end

    if (dead_up && !dead_dn) begin
      if (dead_up_x > DEAD_MAX_X) begin
        dead_nx = DEAD_MAX_X[DEAD_W-1:0];
        clamp   = 1'b1;
      end else begin
        dead_nx = dead_up_x[DEAD_W-1:0];
      end
    end else if (dead_dn && !dead_up) begin
      if (dead_dn_x[DEAD_W]) begin
        dead_nx = '0;
        clamp   = 1'b1;
      end else begin
        dead_nx = dead_dn_x[DEAD_W-1:0];
      end
    end

`ifdef DEAD_CLAMP_EN
    // Both dead-time bands must fit inside the shorter of the on and off
    // phases. The check runs every cycle. Because the invariant already holds
    // for the current shadow, it can only bite when a key moved something.
    duty_rem = DUTY_MAX_D - duty_nx;
    duty_min = (duty_nx < duty_rem) ? duty_nx : duty_rem;
    dead_lim = duty_min >> 1;
    if (CW'(dead_nx) > CW'(dead_lim)) begin
      dead_nx = DEAD_W'(dead_lim);
      clamp   = 1'b1;
    end
`endif

    changed = (duty_nx != duty_sh) || (dead_nx != dead_sh);
  end

  // Commit FSM: next state and commit strobe.
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (changed) state_nx = PENDING;
      end
      PENDING: begin
        if (period_end) begin
          commit = 1'b1;
          // If a new edit arrives on the commit cycle, stay pending for it.
          if (!changed) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign upd_pending = (state == PENDING);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      duty_sh  <= DUTY_W'(DUTY_INIT);
      dead_sh  <= DEAD_W'(DEAD_INIT);
      duty_out <= DUTY_W'(DUTY_INIT);
      dead_out <= DEAD_W'(DEAD_INIT);
      sat      <= 1'b0;
    end else begin
      duty_sh <= duty_nx;
      dead_sh <= dead_nx;
      sat     <= clamp;
      // Outputs take the shadow as it stood before this cycle's edit.
      if (commit) begin
        duty_out <= duty_sh;
        dead_out <= dead_sh;
      end
    end
  end

endmodule

// File: tb/tb_pwm_param_ctrl.sv
module tb_pwm_param_ctrl;

  localparam int DUTY_MAX  = 100;
  localparam int DUTY_STEP = 5;
  localparam int DUTY_INIT = 50;
  localparam int DEAD_MAX  = 40;
  localparam int DEAD_STEP = 1;
  localparam int DEAD_INIT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keyVal = 4'hF;
  logic       period_end = 1'b0;
  logic [7:0] duty_out;
  logic [5:0] dead_out;
  logic       upd_pending;
  logic       sat;

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 1'b0;

  // Model of the specified behaviour, in plain integers.
  int m_duty = DUTY_INIT, m_dead = DEAD_INIT;
  int m_oduty = DUTY_INIT, m_odead = DEAD_INIT;
  bit m_pend = 1'b0, m_sat = 1'b0;
  int nd, ne, lim;
  bit s, cm;

  pwm_param_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .keyVal     (keyVal),
    .period_end (period_end),
    .duty_out   (duty_out),
    .dead_out   (dead_out),
    .upd_pending(upd_pending),
    .sat        (sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_duty = DUTY_INIT; m_dead = DEAD_INIT;
      m_oduty = DUTY_INIT; m_odead = DEAD_INIT;
      m_pend = 1'b0; m_sat = 1'b0;
    end else begin
      cm = m_pend && period_end;
      if (cm) begin
        m_oduty = m_duty;
        m_odead = m_dead;
      end
      nd = m_duty; ne = m_dead; s = 1'b0;
      if (!keyVal[0] && keyVal[1]) begin
        nd = m_duty + DUTY_STEP;
        if (nd > DUTY_MAX) begin nd = DUTY_MAX; s = 1'b1; end
      end else if (!keyVal[1] && keyVal[0]) begin
        nd = m_duty - DUTY_STEP;
        if (nd < 0) begin nd = 0; s = 1'b1; end
      end
      if (!keyVal[2] && keyVal[3]) begin
        ne = m_dead + DEAD_STEP;
        if (ne > DEAD_MAX) begin ne = DEAD_MAX; s = 1'b1; end
      end else if (!keyVal[3] && keyVal[2]) begin
        ne = m_dead - DEAD_STEP;
        if (ne < 0) begin ne = 0; s = 1'b1; end
      end
`ifdef DEAD_CLAMP_EN
      lim = ((nd < DUTY_MAX - nd) ? nd : DUTY_MAX - nd) / 2;
      if (ne > lim) begin ne = lim; s = 1'b1; end
`endif
      if (nd != m_duty || ne != m_dead) m_pend = 1'b1;
      else if (cm)                      m_pend = 1'b0;
      m_duty = nd; m_dead = ne; m_sat = s;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_duty_out", int'(duty_out), m_oduty);
      check("cyc_dead_out", int'(dead_out), m_odead);
      check("cyc_upd_pending", int'(upd_pending), int'(m_pend));
      check("cyc_sat", int'(sat), int'(m_sat));
    end
  end

  // One stimulus cycle, followed by a return to idle inputs. Returns 1 ns
  // after the edge that consumed the stimulus.
  task automatic apply(input logic [3:0] k, input logic pe);
    @(posedge clock); #1;
    keyVal = k; period_end = pe;
    @(posedge clock); #1;
    keyVal = 4'hF; period_end = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
  endtask

  initial begin
    int sat_cnt;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    #20 reset = 1'b1;
    #1;
    check("reset_duty", int'(duty_out), 50);
    check("reset_dead", int'(dead_out), 2);
    check("reset_pend", int'(upd_pending), 0);
    check("reset_sat", int'(sat), 0);

    // Duty up, no period_end, then commit.
    apply(4'b1110, 1'b0);
    check("up_pend", int'(upd_pending), 1);
    check("up_duty_held", int'(duty_out), 50);
    apply(4'b1111, 1'b1);
    check("up_commit_duty", int'(duty_out), 55);
    check("up_commit_pend", int'(upd_pending), 0);

    // Twelve duty-down pulses from reset.
    do_reset();
    sat_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      apply(4'b1101, 1'b0);
`ifdef DEAD_CLAMP_EN
      check("down_sat", int'(sat), (i >= 9) ? 1 : 0);
`else
      check("down_sat", int'(sat), (i >= 10) ? 1 : 0);
`endif
    end
    apply(4'b1111, 1'b1);
    check("down_commit_duty", int'(duty_out), 0);
    apply(4'b1101, 1'b0);
    check("down_more_pend", int'(upd_pending), 0);
    check("down_more_sat", int'(sat), 1);

    // Up and down together on duty: ignored.
    apply(4'b1100, 1'b0);
    check("both_pend", int'(upd_pending), 0);
    check("both_sat", int'(sat), 0);
    apply(4'b1111, 1'b1);
    check("both_duty", int'(duty_out), 0);

    // Edit on the commit cycle.
    do_reset();
    apply(4'b1110, 1'b0);
    apply(4'b1110, 1'b0);
    apply(4'b1010, 1'b1);
    check("same_cyc_duty", int'(duty_out), 60);
    check("same_cyc_dead", int'(dead_out), 2);
    check("same_cyc_pend", int'(upd_pending), 1);
    apply(4'b1111, 1'b1);
    check("same_cyc_duty2", int'(duty_out), 65);
    check("same_cyc_dead2", int'(dead_out), 3);
    check("same_cyc_pend2", int'(upd_pending), 0);

    // Dead-time ceiling.
    do_reset();
    for (int i = 0; i < 39; i++) apply(4'b1011, 1'b0);
    check("dead_last_sat", int'(sat), 1);
    apply(4'b1111, 1'b1);
`ifdef DEAD_CLAMP_EN
    check("dead_max", int'(dead_out), 25);
`else
    check("dead_max", int'(dead_out), 40);
`endif

    // Asynchronous reset while pending.
    apply(4'b1110, 1'b0);
    apply(4'b1011, 1'b0);
    check("async_pre_pend", int'(upd_pending), 1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("async_duty", int'(duty_out), 50);
    check("async_dead", int'(dead_out), 2);
    check("async_pend", int'(upd_pending), 0);
    @(posedge clock); #3;
    reset = 1'b1;
    apply(4'b1111, 1'b1);
    check("async_lost_duty", int'(duty_out), 50);

    repeat (3) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_param_ctrl.md
Name: pwm_param_ctrl

Overview:
- Consumes the debounced key event bus (four active-low, one-cycle key pulses) and turns it into PWM duty and dead-time settings.
- Edits go to shadow registers, which are committed to the active outputs only at a PWM period boundary, so the downstream PWM/dead-time generator never sees a mid-period change.
- Sits between the key debouncer and the PWM core.

Parameters:
DUTY_W, 8, width of duty registers
DEAD_W, 6, width of dead-time registers
DUTY_MAX, 100, upper duty limit (duty units)
DUTY_STEP, 5, duty increment/decrement per key event
DUTY_INIT, 50, duty value at reset
DEAD_MAX, 40, upper dead-time limit (clock ticks)
DEAD_STEP, 1, dead-time increment/decrement per key event
DEAD_INIT, 2, dead-time value at reset

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
keyVal  in  4  key events, active-low one-cycle pulses; [0] duty up, [1] duty down, [2] dead up, [3] dead down
period_end  in  1  one-cycle high pulse from PWM counter at period wrap
duty_out  out  DUTY_W  committed duty
dead_out  out  DEAD_W  committed dead time
upd_pending  out  1  shadow differs from committed (commit awaiting period_end)
sat  out  1  one-cycle pulse: last accepted key hit a limit

Behaviour:
- Reset (reset=0, asynchronous):
  - duty shadow and duty_out = DUTY_INIT; dead shadow and dead_out = DEAD_INIT.
  - upd_pending=0, sat=0; FSM in IDLE.
- Key decode: a key is active in a cycle when keyVal bit=0. keyVal is already in the clock domain; no extra synchroniser.
- Shadow update latency: 1 clock. The shadow takes its new value on the edge after the cycle in which keyVal is low.
- Duty up: shadow = min(shadow+DUTY_STEP, DUTY_MAX). Duty down: shadow = max(shadow−DUTY_STEP, 0). Evaluate with one extra bit; no wrap-around permitted.
- Dead time up/down: same rules using DEAD_STEP, DEAD_MAX and 0.
- Up and down on the same parameter in the same cycle: both ignored, no change, sat=0.
- Duty and dead keys in the same cycle: both applied independently.
- sat: pulses high for 1 cycle, coincident with the shadow update, when any accepted key was clamped. This includes a key pressed while already at the limit.
- Commit FSM:
  - IDLE: upd_pending=0. Any shadow value change → PENDING.
  - PENDING: upd_pending=1. On period_end=1, duty_out/dead_out ← current shadow values → IDLE.
  - A key that changes the shadow in the same cycle as period_end: outputs take the pre-update shadow, the new shadow is registered, and the FSM stays in PENDING.
  - A key at saturation (no value change) does not enter PENDING.
- period_end in IDLE: no effect.
- duty_out/dead_out change only on the edge after period_end high in PENDING; they are otherwise stable.
- Reset mid-PENDING: everything returns to INIT values and the pending edit is lost.

Optional Feature:
- Macro DEAD_CLAMP_EN.
- Defined:
  - After every shadow update, the dead shadow is additionally clamped so that 2·dead ≤ min(duty, DUTY_MAX−duty). The clamp uses the new duty shadow.
  - A clamp caused by a duty change also pulses sat and counts as a shadow change.
  - Reset values must satisfy the constraint.
- Undefined: dead time is limited only by DEAD_MAX and 0; duty has no effect on dead time.

Test Plan:
- Reset, then pulse keyVal=4'b1110 once, no period_end → shadow duty 55, duty_out stays 50, upd_pending=1; pulse period_end → next cycle duty_out=55, upd_pending=0.
- Starting at reset values, 12 duty-down pulses, then period_end → duty_out=0; sat high on the 11th and 12th updates; a further down pulse leaves upd_pending=0.
- keyVal=4'b1100 for one cycle → duty and dead shadows unchanged, no sat, upd_pending=0.
- keyVal=4'b1010 (duty up + dead up) in the same cycle as period_end while PENDING with shadow duty 60 → duty_out=60; shadow becomes duty 65, dead +1; upd_pending stays 1.
- 39 dead-up pulses, then period_end → dead_out=40 (DEAD_MAX), sat on the last pulses. With DEAD_CLAMP_EN and duty 50 → dead_out=25.
- Assert reset low mid-PENDING (asynchronously, between edges) → outputs return to 50/2 immediately and upd_pending=0.
